// File: rtl/axi_chn_slice_pkg.sv
// rtl/axi_chn_slice_pkg.sv - shared AXI channel payload widths and log2 helper
package axi_chn_slice_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    // Address channel payload: id, addr, len, size, burst, lock, cache, prot
    localparam int AX_PAYLOAD_W = AXI_ID_W + AXI_ADDR_W + 8 + 3 + 2 + 1 + 4 + 3;
    localparam int AW_PAYLOAD_W = AX_PAYLOAD_W;
    localparam int AR_PAYLOAD_W = AX_PAYLOAD_W;
    localparam int W_PAYLOAD_W  = AXI_DATA_W + AXI_DATA_W / 8 + 1;
    localparam int R_PAYLOAD_W  = AXI_ID_W + AXI_DATA_W + 2 + 1;
    localparam int B_PAYLOAD_W  = AXI_ID_W + 2;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_chn_slice_regfile.sv
// rtl/axi_chn_slice_regfile.sv - DEPTH x DW storage, sync write, async read
module axi_chn_slice_regfile #(
    parameter int DW    = 64,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_chn_slice.sv
// rtl/axi_chn_slice.sv - registered buffer for one AXI valid/ready channel
module axi_chn_slice
    import axi_chn_slice_pkg::*;
#(
    parameter int DW     = 64,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0,
    localparam int AW    = log2_ceil(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] M_DATA,
    output logic [AW:0]   LEVEL
);

    if (BYPASS) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{CLK, RST, FLUSH};

        assign M_VALID = S_VALID;
        assign S_READY = M_READY;
        assign M_DATA  = S_DATA;
        assign LEVEL   = '0;
    end else begin : g_buffer
        localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic          full;
        logic          push;
        logic          pop;

        assign full    = (count == FULL_LEVEL);
        // Ready never looks at M_READY, so no combinational path crosses the slice.
        assign S_READY = !full && !RST && !FLUSH;
        assign M_VALID = (count != '0);
        assign push    = S_VALID && S_READY;
        assign pop     = M_VALID && M_READY;
        assign LEVEL   = count;

        always_ff @(posedge CLK) begin
            if (RST || FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            end
        end

        axi_chn_slice_regfile #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_regfile (
            .clk     (CLK),
            .wr_en   (push),
            .wr_addr (wr_ptr),
            .wr_data (S_DATA),
            .rd_addr (rd_ptr),
            .rd_data (M_DATA)
        );
    end

endmodule

// File: tb/tb_axi_chn_slice.sv
// tb/tb_axi_chn_slice.sv - queue-model bench for buffered and bypass slices
module tb_axi_chn_slice;

    logic       clk = 1'b0;
    logic       rst, flush, s_valid, m_ready;
    logic [7:0] s_data;
    logic       s_ready, m_valid;
    logic [7:0] m_data;
    logic [2:0] level;

    logic       b_s_valid, b_m_ready;
    logic [7:0] b_s_data;
    logic       b_s_ready, b_m_valid;
    logic [7:0] b_m_data;
    logic [2:0] b_level;

    int tests = 0;
    int fails = 0;
    byte unsigned q[$];

    always #5 clk = ~clk;

    axi_chn_slice #(.DW(8), .DEPTH(4), .BYPASS(1'b0)) u_dut (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
        .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
        .LEVEL(level)
    );

    axi_chn_slice #(.DW(8), .DEPTH(4), .BYPASS(1'b1)) u_byp (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .S_VALID(b_s_valid), .S_READY(b_s_ready), .S_DATA(b_s_data),
        .M_VALID(b_m_valid), .M_READY(b_m_ready), .M_DATA(b_m_data),
        .LEVEL(b_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare against the queue model, then advance the model.
    task automatic step(input logic sv, input logic [7:0] sd, input logic mr,
                        input logic fl, input logic rs);
        bit exp_ready, do_push, do_pop;
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl; rst = rs;
        b_s_valid = 1'($urandom); b_m_ready = 1'($urandom); b_s_data = 8'($urandom);
        #1;
        exp_ready = (q.size() < 4) && !rs && !fl;
        chk("s_ready", int'(s_ready), int'(exp_ready));
        chk("m_valid", int'(m_valid), int'(q.size() != 0));
        chk("level", int'(level), q.size());
        if (q.size() != 0) chk("m_data", int'(m_data), int'(q[0]));
        chk("byp_m_valid", int'(b_m_valid), int'(b_s_valid));
        chk("byp_s_ready", int'(b_s_ready), int'(b_m_ready));
        chk("byp_m_data", int'(b_m_data), int'(b_s_data));
        chk("byp_level", int'(b_level), 0);
        do_push = sv && exp_ready;
        do_pop  = mr && (q.size() != 0);
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(sd);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_data = '0;
        @(negedge clk);

        // Reset gating: 0xAA offered during reset must never appear
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        chk("lit_reset_level", int'(level), 0);
        chk("lit_reset_m_valid", int'(m_valid), 0);
        idle();
        chk("lit_release_s_ready", int'(s_ready), 1);
        chk("lit_release_m_valid", int'(m_valid), 0);

        // Fill and stall
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("lit_full_level", int'(level), 4);
        chk("lit_full_s_ready", int'(s_ready), 0);
        chk("lit_full_m_data", int'(m_data), 8'h11);

        // Full plus pop: 0x55 refused this cycle, accepted the next
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("lit_fullpop_level", int'(level), 3);
        chk("lit_fullpop_m_data", int'(m_data), 8'h22);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("lit_accept55_level", int'(level), 4);
        drain();

        // Streaming with pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("lit_stream_level", int'(level), 1);
            chk("lit_stream_m_data", int'(m_data), i);
        end
        drain();

        // Flush with concurrent pop and rejected push
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        chk("lit_preflush_m_data", int'(m_data), 8'hA1);
        step(1'b1, 8'hB0, 1'b1, 1'b1, 1'b0);
        chk("lit_flush_level", int'(level), 0);
        chk("lit_flush_m_valid", int'(m_valid), 0);
        idle();
        chk("lit_flush_s_ready", int'(s_ready), 1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
